triangle_fifo: RTL and testbench
================================

Name: triangle_fifo

Overview:
Buffers the vertex stream and the per-triangle colour stream, and pairs each group of three consecutive vertices with one colour. Sits between the vertex-transform stage and the rasterizer. Emits each vertex with its triangle's colour over a valid/ready handshake. A triangle is released only when all three of its vertices and its colour have been written.

Parameters:
TRI_DEPTH, 64, triangle capacity (power of two); vertex storage is 4*TRI_DEPTH words, colour storage is TRI_DEPTH words.

Ports:
clk_in  input  1  system clock, rising edge
rst_in  input  1  asynchronous, active-low reset
vertex_valid_in  input  1  vertex_in is written this cycle; there is no input backpressure
vertex_in  input  [3:0][31:0]  homogeneous vertex {x,y,z,w}, FP32 words
color_valid_in  input  1  color_in is written this cycle
color_in  input  12  RGB444 colour of the next triangle
valid_out  output  1  vertex_out/color_out hold a valid beat
ready_in  input  1  downstream accepts the beat
vertex_out  output  [3:0][31:0]  vertex being emitted
color_out  output  12  colour of the emitted vertex's triangle

Behaviour:
- Reset (rst_in low, asynchronous): all pointers, counters and vertex index cleared; valid_out=0; vertex_out=0; color_out=0. Reset at any time discards all stored data, including a partially written triangle.
- Pointers are log2(TRI_DEPTH)+1 bits wide (extra wrap bit): vtx_wr_tri, col_wr_tri, rd_tri. Indices are vtx_idx (0..2) and rd_idx (0..2).
- Vertex write:
  - Address is {vtx_wr_tri[low bits], vtx_idx}; slot 3 is unused.
  - vtx_idx increments on each write. After index 2 it returns to 0 and vtx_wr_tri increments.
  - Dropped silently if vtx_wr_tri - rd_tri == TRI_DEPTH (full).
- Colour write: written at col_wr_tri, which then increments. Dropped if col_wr_tri - rd_tri == TRI_DEPTH.
- Vertex and colour writes may occur in the same cycle. The colour may arrive before, during or after its vertices.
- A triangle is complete when rd_tri < min(vtx_wr_tri, col_wr_tri), compared modulo the pointer width.
- Read side:
  - Vertex RAM and colour RAM each have 1-cycle registered read latency. Output is taken from a prefetch register with a one-entry skid, giving first-word-fall-through behaviour.
  - First valid_out rises exactly 2 cycles after the clock edge that completes the triangle, if the output is otherwise empty.
  - Beats are the vertices of rd_tri in order 0,1,2, each carrying the same color_out.
  - A beat transfers when valid_out && ready_in. After beat 2 transfers, rd_tri increments and rd_idx returns to 0.
- With ready_in held high and triangles available, the block streams one vertex per cycle with no bubbles, including across triangle boundaries.
- Backpressure: while valid_out && !ready_in, vertex_out and color_out stay stable and valid_out stays high.
- Incomplete triangles (fewer than 3 vertices, or no colour) are never emitted. valid_out stays 0 indefinitely.
- Storage is freed only after beat 2 of a triangle transfers.

Decomposition:
- Shared graphics package: vertex_t (logic [3:0][31:0]), color_t (logic [11:0]), VERTS_PER_TRI=3.
- Storage uses two instances of the existing xilinx_dual_port_ram: 128-bit × 4*TRI_DEPTH for vertices, 12-bit × TRI_DEPTH for colours.
- One new sub-module: triangle_fifo_skid. It holds the output prefetch/skid register that absorbs RAM latency under ready_in deassertion.

Test Plan:
- Reset: pulse rst_in low for 1 cycle -> valid_out=0, vertex_out=0, color_out=0 during and after reset.
- Lone vertex: ready_in=1; write one vertex {AAAAAAAA,3F000000,42200000,43200000}, no colour; wait 10 cycles -> valid_out stays 0.
- Full triangle: write V0,V1,V2 on consecutive cycles, with colour 12'hF00 alongside V0 -> valid_out rises 2 cycles after V2's edge. Three consecutive beats V0,V1,V2, each with color_out=F00; then valid_out=0.
- Colour late and backpressure: write 3 vertices, colour 12'h0A5 five cycles later, with ready_in=0 -> valid_out rises and holds V0/0A5 stable. Raising ready_in yields V0,V1,V2 back-to-back.
- Full/drop: ready_in=0; write TRI_DEPTH+1 triangles (vertices and colours) -> the extra triangle is dropped. Draining yields exactly 3*TRI_DEPTH beats, in order, with matching colours; pointer wrap verified by a second fill.
- Mid-stream reset: assert rst_in during the emission of beat 1 -> valid_out drops immediately. After release, no stale beats; new triangles stream correctly.

Source files
------------

// File: rtl/triangle_fifo_pkg.sv
// Shared graphics types for the triangle FIFO: vertex/colour words and the
// output beat that pairs a vertex with its triangle colour.
package triangle_fifo_pkg;

    localparam int VERTS_PER_TRI = 3;

    typedef logic [3:0][31:0] vertex_t;
    typedef logic [11:0]      color_t;

    typedef struct packed {
        vertex_t vertex;
        color_t  color;
    } beat_t;

    // Vertex index within a triangle: 0,1,2 then back to 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'(VERTS_PER_TRI - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic is_last_idx(input logic [1:0] idx);
        return idx == 2'(VERTS_PER_TRI - 1);
    endfunction

endpackage

// File: rtl/triangle_fifo_skid.sv
// Two-entry output buffer (presented register plus skid) that absorbs the
// RAM read in flight when the downstream stalls.
module triangle_fifo_skid
    import triangle_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  room,
    output logic  out_valid,
    input  logic  out_ready,
    output beat_t out_beat
);

    logic       skid_valid;
    beat_t      skid_beat;
    logic       pop;
    logic [2:0] level_next;

    // valid/ready: a beat moves when out_valid && out_ready on a rising edge;
    // out_valid never drops and out_beat never changes while stalled.
    assign pop = out_valid && out_ready;

    // room: a read issued now still fits once it lands next cycle.
    always_comb begin
        level_next = 3'(out_valid) + 3'(skid_valid) + 3'(in_valid) - 3'(pop);
        room       = level_next < 3'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_beat   <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
        end else if (!out_valid || pop) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_beat   <= skid_beat;
                skid_valid <= in_valid;
                if (in_valid) begin
                    skid_beat <= in_beat;
                end
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_beat <= in_beat;
                end
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_beat  <= in_beat;
        end
    end

endmodule

// File: rtl/xilinx_dual_port_ram.sv
// Simple dual-port block RAM: one write port, one read port with a
// registered (1-cycle) read.
module xilinx_dual_port_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clka,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              clkb,
    input  logic              enb,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clka) begin
        if (wea) begin
            mem[addra] <= dina;
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            doutb <= mem[addrb];
        end
    end

endmodule

// File: rtl/triangle_fifo.sv
// Pairs every three consecutive vertices with one colour and streams the
// vertices of complete triangles, first-word-fall-through, to the rasterizer.
module triangle_fifo
    import triangle_fifo_pkg::*;
#(
    parameter int TRI_DEPTH = 64
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    vertex_valid_in,
    input  vertex_t vertex_in,
    input  logic    color_valid_in,
    input  color_t  color_in,
    output logic    valid_out,
    input  logic    ready_in,
    output vertex_t vertex_out,
    output color_t  color_out
);

    localparam int AW = $clog2(TRI_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_DIST = PW'(TRI_DEPTH);

    logic [PW-1:0] vtx_wr_tri, col_wr_tri, rd_tri, fetch_tri;
    logic [1:0]    vtx_idx, rd_idx, fetch_idx;
    logic [PW-1:0] vtx_used, col_used;
    logic          vtx_we, col_we;
    logic          fetch_avail, fetch_go, rd_pending;
    logic          skid_room, pop;
    vertex_t       vtx_rd;
    color_t        col_rd;
    beat_t         in_beat, out_beat;

    // Full counts only whole vertex groups; a partial triangle sits in the
    // slot just past them and is protected by the same check.
    assign vtx_used = vtx_wr_tri - rd_tri;
    assign col_used = col_wr_tri - rd_tri;
    assign vtx_we   = vertex_valid_in && (vtx_used != FULL_DIST);
    assign col_we   = color_valid_in && (col_used != FULL_DIST);

    // The fetch pointer runs ahead of rd_tri by at most the two buffered beats.
    assign fetch_avail = (fetch_tri != vtx_wr_tri) && (fetch_tri != col_wr_tri);
    assign fetch_go    = fetch_avail && skid_room;
    assign pop         = valid_out && ready_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vtx_wr_tri <= '0;
            vtx_idx    <= '0;
            col_wr_tri <= '0;
            rd_tri     <= '0;
            rd_idx     <= '0;
            fetch_tri  <= '0;
            fetch_idx  <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (vtx_we) begin
                vtx_idx <= next_idx(vtx_idx);
                if (is_last_idx(vtx_idx)) begin
                    vtx_wr_tri <= vtx_wr_tri + PW'(1);
                end
            end
            if (col_we) begin
                col_wr_tri <= col_wr_tri + PW'(1);
            end
            if (fetch_go) begin
                fetch_idx <= next_idx(fetch_idx);
                if (is_last_idx(fetch_idx)) begin
                    fetch_tri <= fetch_tri + PW'(1);
                end
            end
            rd_pending <= fetch_go;
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
                if (is_last_idx(rd_idx)) begin
                    rd_tri <= rd_tri + PW'(1);
                end
            end
        end
    end

    xilinx_dual_port_ram #(
        .DATA_W ($bits(vertex_t)),
        .DEPTH  (4 * TRI_DEPTH)
    ) u_vertex_ram (
        .clka  (clk_in),
        .wea   (vtx_we),
        .addra ({vtx_wr_tri[AW-1:0], vtx_idx}),
        .dina  (vertex_in),
        .clkb  (clk_in),
        .enb   (fetch_go),
        .addrb ({fetch_tri[AW-1:0], fetch_idx}),
        .doutb (vtx_rd)
    );

    xilinx_dual_port_ram #(
        .DATA_W ($bits(color_t)),
        .DEPTH  (TRI_DEPTH)
    ) u_color_ram (
        .clka  (clk_in),
        .wea   (col_we),
        .addra (col_wr_tri[AW-1:0]),
        .dina  (color_in),
        .clkb  (clk_in),
        .enb   (fetch_go),
        .addrb (fetch_tri[AW-1:0]),
        .doutb (col_rd)
    );

    assign in_beat = '{vertex: vtx_rd, color: col_rd};

    triangle_fifo_skid u_skid (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .in_valid  (rd_pending),
        .in_beat   (in_beat),
        .room      (skid_room),
        .out_valid (valid_out),
        .out_ready (ready_in),
        .out_beat  (out_beat)
    );

    assign vertex_out = out_beat.vertex;
    assign color_out  = out_beat.color;

endmodule

// File: tb/tb_triangle_fifo.sv
// Directed and randomized bench for triangle_fifo against a queue-based
// model of stored vertices and colours.
module tb_triangle_fifo;
    import triangle_fifo_pkg::*;

    localparam int TRI_DEPTH = 64;

    logic    clk_in = 1'b0;
    logic    rst_in = 1'b0;
    logic    vertex_valid_in = 1'b0;
    vertex_t vertex_in = '0;
    logic    color_valid_in = 1'b0;
    color_t  color_in = '0;
    logic    valid_out;
    logic    ready_in = 1'b0;
    vertex_t vertex_out;
    color_t  color_out;

    always #5 clk_in = ~clk_in;

    triangle_fifo #(.TRI_DEPTH(TRI_DEPTH)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .vertex_valid_in (vertex_valid_in),
        .vertex_in       (vertex_in),
        .color_valid_in  (color_valid_in),
        .color_in        (color_in),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .vertex_out      (vertex_out),
        .color_out       (color_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_beats  = 0;

    // Model: accepted vertices/colours not yet freed, plus the beat index.
    vertex_t exp_vtx_q[$];
    color_t  exp_col_q[$];
    int      m_idx = 0;

    function automatic logic model_avail();
        return (exp_vtx_q.size() >= 3) && (exp_col_q.size() >= 1);
    endfunction

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic model_clear();
        exp_vtx_q.delete();
        exp_col_q.delete();
        m_idx = 0;
    endtask

    // One clock: drive after a negedge, score the edge, return at the next negedge.
    task automatic cycle(input logic vv, input vertex_t v, input logic cv,
                         input color_t c, input logic rdy);
        logic vacc, cacc, xfer;
        vertex_valid_in = vv;
        vertex_in       = v;
        color_valid_in  = cv;
        color_in        = c;
        ready_in        = rdy;
        xfer = valid_out && rdy;
        if (xfer) begin
            n_beats++;
            chk("beat_has_data", 160'(model_avail()), 160'(1));
            if (model_avail()) begin
                chk("beat_vertex", 160'(vertex_out), 160'(exp_vtx_q[m_idx]));
                chk("beat_color", 160'(color_out), 160'(exp_col_q[0]));
            end
        end
        vacc = vv && ((exp_vtx_q.size() / 3) != TRI_DEPTH);
        cacc = cv && (exp_col_q.size() != TRI_DEPTH);
        @(posedge clk_in);
        if (xfer && model_avail()) begin
            if (m_idx == 2) begin
                repeat (3) void'(exp_vtx_q.pop_front());
                void'(exp_col_q.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (vacc) exp_vtx_q.push_back(v);
        if (cacc) exp_col_q.push_back(c);
        @(negedge clk_in);
        chk("valid_needs_tri", 160'(valid_out && !model_avail()), 160'(0));
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        vertex_valid_in = 1'b0;
        color_valid_in  = 1'b0;
        #1;
        chk("rst_valid", 160'(valid_out), 160'(0));
        chk("rst_vertex", 160'(vertex_out), 160'(0));
        model_clear();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    function automatic vertex_t rand_vertex();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_and_drain(input int n_tri);
        int i;
        for (int t = 0; t < n_tri; t++) begin
            cycle(1'b1, rand_vertex(), 1'b1, 12'($urandom), 1'b0);
            cycle(1'b1, rand_vertex(), 1'b0, '0, 1'b0);
            cycle(1'b1, rand_vertex(), 1'b0, '0, 1'b0);
        end
        chk("fill_stall_valid", 160'(valid_out), 160'(1));
        n_beats = 0;
        i = 0;
        while (i < 1000 && (model_avail() || valid_out)) begin
            idle(1'b1);
            i++;
        end
        chk("drain_bounded", 160'(model_avail()), 160'(0));
        chk("drain_beats", 160'(n_beats), 160'(3 * TRI_DEPTH));
        chk("drain_valid_low", 160'(valid_out), 160'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vertex_t lone, v0, v1, v2;
        int i;
        lone = {32'hAAAAAAAA, 32'h3F000000, 32'h42200000, 32'h43200000};

        // Reset pulse
        @(negedge clk_in);
        chk("reset_valid", 160'(valid_out), 160'(0));
        chk("reset_vertex", 160'(vertex_out), 160'(0));
        chk("reset_color", 160'(color_out), 160'(0));
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("post_reset_valid", 160'(valid_out), 160'(0));
        chk("post_reset_vertex", 160'(vertex_out), 160'(0));
        chk("post_reset_color", 160'(color_out), 160'(0));

        // Lone vertex never emitted
        cycle(1'b1, lone, 1'b0, '0, 1'b1);
        repeat (10) idle(1'b1);
        chk("lone_valid", 160'(valid_out), 160'(0));
        do_reset();

        // Full triangle, colour alongside V0
        v0 = rand_vertex(); v1 = rand_vertex(); v2 = rand_vertex();
        cycle(1'b1, v0, 1'b1, 12'hF00, 1'b1);
        cycle(1'b1, v1, 1'b0, '0, 1'b1);
        cycle(1'b1, v2, 1'b0, '0, 1'b1);
        chk("tri_lat_e0", 160'(valid_out), 160'(0));
        idle(1'b1);
        chk("tri_lat_e1", 160'(valid_out), 160'(0));
        idle(1'b1);
        chk("tri_lat_e2", 160'(valid_out), 160'(1));
        chk("tri_v0", 160'(vertex_out), 160'(v0));
        chk("tri_c0", 160'(color_out), 160'(12'hF00));
        idle(1'b1);
        chk("tri_valid1", 160'(valid_out), 160'(1));
        chk("tri_v1", 160'(vertex_out), 160'(v1));
        idle(1'b1);
        chk("tri_valid2", 160'(valid_out), 160'(1));
        chk("tri_v2", 160'(vertex_out), 160'(v2));
        chk("tri_c2", 160'(color_out), 160'(12'hF00));
        idle(1'b1);
        chk("tri_done", 160'(valid_out), 160'(0));

        // Late colour under backpressure
        v0 = rand_vertex(); v1 = rand_vertex(); v2 = rand_vertex();
        cycle(1'b1, v0, 1'b0, '0, 1'b0);
        cycle(1'b1, v1, 1'b0, '0, 1'b0);
        cycle(1'b1, v2, 1'b0, '0, 1'b0);
        repeat (4) idle(1'b0);
        chk("late_no_color", 160'(valid_out), 160'(0));
        cycle(1'b0, '0, 1'b1, 12'h0A5, 1'b0);
        idle(1'b0);
        chk("late_lat_e1", 160'(valid_out), 160'(0));
        idle(1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("hold_valid", 160'(valid_out), 160'(1));
            chk("hold_vertex", 160'(vertex_out), 160'(v0));
            chk("hold_color", 160'(color_out), 160'(12'h0A5));
            idle(1'b0);
        end
        idle(1'b1);
        chk("bp_v1", 160'(vertex_out), 160'(v1));
        chk("bp_valid1", 160'(valid_out), 160'(1));
        idle(1'b1);
        chk("bp_v2", 160'(vertex_out), 160'(v2));
        chk("bp_c2", 160'(color_out), 160'(12'h0A5));
        idle(1'b1);
        chk("bp_done", 160'(valid_out), 160'(0));

        // Fill past capacity, drain, then again to wrap the pointers
        fill_and_drain(TRI_DEPTH + 1);
        fill_and_drain(TRI_DEPTH + 1);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            cycle(1'($urandom_range(0, 1)), rand_vertex(),
                  ($urandom_range(0, 5) == 0), 12'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        i = 0;
        while (i < 1000 && (model_avail() || valid_out)) begin
            idle(1'b1);
            i++;
        end
        chk("rand_drained", 160'(model_avail()), 160'(0));
        chk("rand_valid_low", 160'(valid_out), 160'(0));
        do_reset();

        // Mid-stream reset during beat 1
        v0 = rand_vertex(); v1 = rand_vertex(); v2 = rand_vertex();
        cycle(1'b1, v0, 1'b1, 12'h123, 1'b1);
        cycle(1'b1, v1, 1'b0, '0, 1'b1);
        cycle(1'b1, v2, 1'b0, '0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("mid_beat1_shown", 160'(vertex_out), 160'(v1));
        #2;
        rst_in = 1'b0;
        #1;
        chk("mid_rst_valid", 160'(valid_out), 160'(0));
        chk("mid_rst_vertex", 160'(vertex_out), 160'(0));
        model_clear();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        repeat (6) idle(1'b1);
        chk("mid_no_stale", 160'(valid_out), 160'(0));
        n_beats = 0;
        cycle(1'b1, rand_vertex(), 1'b0, '0, 1'b1);
        cycle(1'b1, rand_vertex(), 1'b1, 12'h456, 1'b1);
        cycle(1'b1, rand_vertex(), 1'b0, '0, 1'b1);
        repeat (10) idle(1'b1);
        chk("mid_new_beats", 160'(n_beats), 160'(3));
        chk("mid_new_done", 160'(valid_out), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
